// File: rtl/fc_pkg.sv
// Shared types and helpers for dense layers.
// Widths, accumulator sizing, unsigned 8-bit saturation.
package fc_pkg;

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;

  // Accumulator width that holds n full-scale products without overflow
  function automatic int acc_w(input int n);
    return PROD_W + $clog2(n) + 1;
  endfunction

  // Clamp an unsigned value to the 8-bit range instead of wrapping
  function automatic logic [DATA_W-1:0] sat_u8(input logic [31:0] value);
    if (value > 32'd255)
      return 8'hFF;
    else
      return value[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fc_neuron.sv
// One dense-layer neuron: dot product, scale, bias add and saturation.
// Purely combinational; the layer top registers the result.
module fc_neuron
  import fc_pkg::*;
#(
  parameter int N     = 10,
  parameter int SHIFT = 0
) (
  input  logic [DATA_W-1:0] x_i [N],
  input  logic [DATA_W-1:0] w_i [N],
  input  logic [DATA_W-1:0] bias_i,
  output logic [DATA_W-1:0] y_o
);

  localparam int ACC_W = acc_w(N);

  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] scaled;

  // Multiply-accumulate over the whole row, then scale, bias and clamp
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + ACC_W'(x_i[i]) * ACC_W'(w_i[i]);
    end
    scaled = (sum >> SHIFT) + ACC_W'(bias_i);
    y_o    = sat_u8(32'(scaled));
  end

endmodule

// File: rtl/fully_connected_layer.sv
// Dense layer of M parallel neurons with a registered output bank.
// One result vector per clock, cleared asynchronously by rst_n.
module fully_connected_layer
  import fc_pkg::*;
#(
  parameter int N     = 10,
  parameter int M     = 5,
  parameter int SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] input_data  [N],
  input  logic [DATA_W-1:0] weights     [M][N],
  input  logic [DATA_W-1:0] biases      [M],
  output logic [DATA_W-1:0] output_data [M]
);

  logic [DATA_W-1:0] out_d [M];
  logic [DATA_W-1:0] out_q [M];

  for (genvar j = 0; j < M; j++) begin : g_neuron
    fc_neuron #(
      .N     (N),
      .SHIFT (SHIFT)
    ) u_neuron (
      .x_i    (input_data),
      .w_i    (weights[j]),
      .bias_i (biases[j]),
      .y_o    (out_d[j])
    );
  end

  // Capture every neuron's result each edge; reset clears the bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < M; j++) out_q[j] <= '0;
    end else begin
      for (int j = 0; j < M; j++) out_q[j] <= out_d[j];
    end
  end

  assign output_data = out_q;

endmodule

// File: tb/tb_fully_connected_layer.sv
// Bench for fully_connected_layer: directed cases plus random vectors.
// Two instances share inputs: SHIFT=0 and SHIFT=2.
module tb_fully_connected_layer;

  localparam int N = 10;
  localparam int M = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_d [N];
  logic [7:0] w    [M][N];
  logic [7:0] b    [M];
  logic [7:0] out0 [M];
  logic [7:0] out2 [M];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fully_connected_layer #(.N(N), .M(M), .SHIFT(0)) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .input_data  (in_d),
    .weights     (w),
    .biases      (b),
    .output_data (out0)
  );

  fully_connected_layer #(.N(N), .M(M), .SHIFT(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .input_data  (in_d),
    .weights     (w),
    .biases      (b),
    .output_data (out2)
  );

  function automatic int model(input int j, input int sh);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(in_d[i]) * int'(w[j][i]);
    s = (s >> sh) + int'(b[j]);
    return (s > 255) ? 255 : s;
  endfunction

  task automatic check(input string tag, input int j,
                       input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, j, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    for (int j = 0; j < M; j++) begin
      check({tag, "/s0"}, j, out0[j], 8'(model(j, 0)));
      check({tag, "/s2"}, j, out2[j], 8'(model(j, 2)));
    end
  endtask

  task automatic set_all(input logic [7:0] xv, input logic [7:0] wv,
                         input logic [7:0] bv);
    for (int i = 0; i < N; i++) in_d[i] = xv;
    for (int j = 0; j < M; j++) begin
      b[j] = bv;
      for (int i = 0; i < N; i++) w[j][i] = wv;
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < N; i++) in_d[i] = 8'(i);
    for (int j = 0; j < M; j++) begin
      b[j] = 8'(j);
      for (int i = 0; i < N; i++) w[j][i] = 8'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset asserted before any clock edge
    set_all(8'hFF, 8'hFF, 8'hFF);
    #1 rst_n = 1'b0;
    #1;
    for (int j = 0; j < M; j++) begin
      check("rst_async", j, out0[j], 8'd0);
      check("rst_async2", j, out2[j], 8'd0);
    end
    step();
    step();
    for (int j = 0; j < M; j++) check("rst_hold", j, out0[j], 8'd0);

    // all ones
    @(negedge clk);
    set_all(8'd1, 8'd1, 8'd0);
    rst_n = 1'b1;
    step();
    for (int j = 0; j < M; j++) begin
      check("ones", j, out0[j], 8'd10);
      check("ones_s2", j, out2[j], 8'd2);
    end

    // ramp inputs with per-neuron bias
    @(negedge clk);
    set_ramp();
    step();
    for (int j = 0; j < M; j++) begin
      check("ramp", j, out0[j], 8'(45 + j));
      check("ramp_s2", j, out2[j], 8'(11 + j));
    end

    // full-scale saturation
    @(negedge clk);
    set_all(8'hFF, 8'hFF, 8'hFF);
    step();
    for (int j = 0; j < M; j++) begin
      check("sat", j, out0[j], 8'd255);
      check("sat_s2", j, out2[j], 8'd255);
    end

    // single nonzero term, independent neurons
    @(negedge clk);
    set_all(8'd0, 8'd0, 8'd0);
    in_d[3] = 8'd7;
    w[2][3] = 8'd9;
    b[0] = 8'd1; b[1] = 8'd2; b[2] = 8'd4; b[3] = 8'd8; b[4] = 8'd16;
    step();
    check("sparse", 0, out0[0], 8'd1);
    check("sparse", 1, out0[1], 8'd2);
    check("sparse", 2, out0[2], 8'd67);
    check("sparse", 3, out0[3], 8'd8);
    check("sparse", 4, out0[4], 8'd16);
    check_model("sparse_m");

    // mid-run reset pulse between edges
    @(negedge clk);
    set_ramp();
    step();
    step();
    for (int j = 0; j < M; j++) check("ramp_ss", j, out0[j], 8'(45 + j));
    #2 rst_n = 1'b0;
    #1;
    for (int j = 0; j < M; j++) begin
      check("midrst", j, out0[j], 8'd0);
      check("midrst_s2", j, out2[j], 8'd0);
    end
    #1 rst_n = 1'b1;
    #1;
    for (int j = 0; j < M; j++) check("rel_noedge", j, out0[j], 8'd0);
    step();
    for (int j = 0; j < M; j++) begin
      check("restore", j, out0[j], 8'(45 + j));
      check("restore_s2", j, out2[j], 8'(11 + j));
    end

    // input change between edges has no effect until the next edge
    @(negedge clk);
    set_all(8'd2, 8'd3, 8'd5);
    #1;
    for (int j = 0; j < M; j++) check("no_edge", j, out0[j], 8'(45 + j));
    step();
    for (int j = 0; j < M; j++) check("after_edge", j, out0[j], 8'd65);

    // random vectors against the reference model
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) in_d[i] = 8'($urandom_range(0, 255));
      for (int j = 0; j < M; j++) begin
        b[j] = 8'($urandom_range(0, 255));
        for (int i = 0; i < N; i++)
          w[j][i] = (t % 2 == 0) ? 8'($urandom_range(0, 3))
                                 : 8'($urandom_range(0, 255));
      end
      step();
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
